// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 8-bit bus computer: step counter, halt latch, strobe decode.
// Define CONDITIONAL_JUMP_EN to add the carry/zero flags register and the JC/JZ instructions.
module control_sequencer #(
  parameter int T_STATES = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       carry_in,
  input  logic       zero_in,
  output logic       co,
  output logic       ce,
  output logic       j,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       bi,
  output logic       eo,
  output logic       su,
  output logic       oi,
  output logic       fi,
  output logic       hlt,
  output logic [2:0] step
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T_LAST = 3'(T_STATES - 1);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control word bit order matches the output concatenation below.
  localparam logic [14:0] CW_CO = 15'h4000;
  localparam logic [14:0] CW_CE = 15'h2000;
  localparam logic [14:0] CW_J  = 15'h1000;
  localparam logic [14:0] CW_MI = 15'h0800;
  localparam logic [14:0] CW_RI = 15'h0400;
  localparam logic [14:0] CW_RO = 15'h0200;
  localparam logic [14:0] CW_II = 15'h0100;
  localparam logic [14:0] CW_IO = 15'h0080;
  localparam logic [14:0] CW_AI = 15'h0040;
  localparam logic [14:0] CW_AO = 15'h0020;
  localparam logic [14:0] CW_BI = 15'h0010;
  localparam logic [14:0] CW_EO = 15'h0008;
  localparam logic [14:0] CW_SU = 15'h0004;
  localparam logic [14:0] CW_OI = 15'h0002;
`ifdef CONDITIONAL_JUMP_EN
  localparam logic [14:0] CW_FI = 15'h0001;
`else
  localparam logic [14:0] CW_FI = 15'h0000;
`endif

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [14:0] cw;
  logic        cf_q, zf_q;
  logic        halt_now;

  assign halt_now = run && !halted_q && (step_q == T2) && (opcode == OP_HLT);

  always_comb begin
    cw = '0;
    if (!reset && !halted_q && run) begin
      case (step_q)
        T0: cw = CW_CO | CW_MI;
        T1: cw = CW_RO | CW_II | CW_CE;
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = CW_IO | CW_MI;
            OP_LDI: cw = CW_IO | CW_AI;
            OP_JMP: cw = CW_IO | CW_J;
`ifdef CONDITIONAL_JUMP_EN
            OP_JC:  cw = cf_q ? (CW_IO | CW_J) : '0;
            OP_JZ:  cw = zf_q ? (CW_IO | CW_J) : '0;
`endif
            OP_OUT: cw = CW_AO | CW_OI;
            default: cw = '0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: cw = CW_RO | CW_AI;
            OP_ADD, OP_SUB: cw = CW_RO | CW_BI;
            OP_STA: cw = CW_AO | CW_RI;
            default: cw = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_ADD: cw = CW_EO | CW_AI | CW_FI;
            OP_SUB: cw = CW_EO | CW_AI | CW_SU | CW_FI;
            default: cw = '0;
          endcase
        end
        default: cw = '0;
      endcase
    end
  end

  // HLT freezes the counter at T2 on the same edge the latch sets.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q | halt_now;
    if (halted_q || !run || halt_now) begin
      step_d = step_q;
    end else if (step_q == T_LAST) begin
      step_d = T0;
    end else begin
      step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

`ifdef CONDITIONAL_JUMP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cf_q <= 1'b0;
      zf_q <= 1'b0;
    end else if (cw[0]) begin
      cf_q <= carry_in;
      zf_q <= zero_in;
    end
  end
`else
  assign cf_q = 1'b0;
  assign zf_q = 1'b0;
  logic unused_flag_inputs;
  assign unused_flag_inputs = carry_in ^ zero_in ^ cf_q ^ zf_q;
`endif

  assign {co, ce, j, mi, ri, ro, ii, io, ai, ao, bi, eo, su, oi, fi} = cw;
  assign hlt  = halted_q;
  assign step = step_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus computer.
- Steps through fixed T-states per instruction and decodes the 4-bit opcode from the instruction register.
- Drives every load/output strobe on the shared 8-bit bus: program counter enable/out/load, MAR, RAM, IR, A, B, ALU, output register and flags.
- Owns the halt state.

Parameters:
- T_STATES, 5, T-states per instruction cycle; legal 5..8; steps 5..T_STATES-1 decode to all-zero control words.

Ports:
- clock  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears step counter, halt latch and flags
- run  input  1  1 = advance one step per clock; 0 = pause (step holds, control word forced to 0)
- opcode  input  4  IR upper nibble
- carry_in  input  1  ALU carry
- zero_in  input  1  ALU zero
- co, ce, j  output  1 each  PC bus out / PC count enable / PC load from bus
- mi  output  1  MAR load
- ri, ro  output  1 each  RAM write / RAM bus out
- ii, io  output  1 each  IR load / IR operand (low nibble) out
- ai, ao  output  1 each  A register load / out
- bi  output  1  B register load
- eo, su  output  1 each  ALU out / subtract select
- oi  output  1  output register load
- fi  output  1  flags register load
- hlt  output  1  halted indicator
- step  output  3  current T-state

Behaviour:
- State: step[2:0], halted, and (with feature) flags {cf, zf}.
- Reset (async): step=0, halted=0, flags=0. While reset is high, all control outputs=0 and hlt=0.
- Control word is a combinational decode of the registered step, opcode and flags. It is valid for the whole clock period; the datapath samples it on the next rising edge.
- Step advance, checked in priority order:
  - halted=1 -> step holds.
  - run=0 -> step holds.
  - step==T_STATES-1 -> step=0.
  - otherwise step+1.
- Pause: while run=0 (or halted=1), every strobe is 0. Resuming continues at the held step with no step skipped or repeated.
- Fetch, all opcodes:
  - T0: co,mi.
  - T1: ro,ii,ce.
- Execute by opcode (unlisted steps = 0):
  - 0 NOP: none.
  - 1 LDA: T2 io,mi; T3 ro,ai.
  - 2 ADD: T2 io,mi; T3 ro,bi; T4 eo,ai,fi.
  - 3 SUB: as ADD with su=1 in T4.
  - 4 STA: T2 io,mi; T3 ao,ri.
  - 5 LDI: T2 io,ai.
  - 6 JMP: T2 io,j.
  - 7 JC, 8 JZ: see Optional Feature.
  - E OUT: T2 ao,oi.
  - F HLT: T2 only; on that rising edge halted<=1.
  - 9..D undefined: executed as NOP.
- Halt:
  - Once halted=1: hlt=1, step frozen at 2, all other strobes 0, run ignored.
  - Only reset clears halted.
- At most one bus driver (co, ro, io, ao, eo) is asserted in any step.
- Opcode is sampled combinationally. It is required stable from T2 through the end of the instruction, which the IR load in T1 guarantees.
- Reset mid-instruction: immediate abort, next cycle after release is T0 fetch.

Optional Feature:
- Macro: CONDITIONAL_JUMP_EN
- Defined:
  - Internal flags register cf/zf loads carry_in/zero_in on a rising edge where fi=1 (ADD/SUB T4, not paused).
  - JC T2: io,j if cf=1, else no strobes.
  - JZ T2: io,j if zf=1, else no strobes.
- Undefined:
  - No flags register.
  - fi tied 0 for all opcodes.
  - Opcodes 7 and 8 execute as NOP.
  - carry_in/zero_in unused.

Test Plan:
- Reset pulse mid-T3, run=1 -> all strobes 0 during reset; first cycle after release step=0 with co=mi=1; next cycle ro=ii=ce=1.
- opcode=2 (ADD), run=1 -> T2 io,mi; T3 ro,bi; T4 eo,ai,fi with su=0; then step wraps to 0. Repeat with opcode=3 -> su=1 in T4 only.
- opcode=F at T2 -> hlt=1 from next cycle, step stays 2, all other strobes 0 for 20 cycles regardless of run; reset -> hlt=0, step=0.
- opcode=1, run dropped at T2 for 3 cycles -> step holds at 2 and strobes are 0; run=1 -> io,mi then ro,ai, no step lost.
- CONDITIONAL_JUMP_EN defined:
  - ADD with carry_in=1 at T4, then opcode=7 -> T2 io,j=1.
  - ADD with carry_in=0, then opcode=7 -> T2 all strobes 0.
  - Same pair of runs for zero_in with opcode=8.
- CONDITIONAL_JUMP_EN undefined: opcode=7/8 with carry_in=zero_in=1 -> T2..T4 all strobes 0; fi never asserted.
